// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM master: opcodes, FSM states, frame widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_ram_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    RD_WAIT  = 3'd3,
    RD_SHIFT = 3'd4,
    CS_HOLD  = 3'd5
  } state_t;

  // Only the read-data opcode keeps the frame open to collect a byte from MISO.
  function automatic logic op_is_read_data(input logic [1:0] op);
    return op == OP_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_ram_master.sv
// SPI master for the SPI slave + RAM wrapper: 10-bit command words out on MOSI, read bytes back from MISO.
// Latency: write frame 1+10+CS_GAP clk, read-data frame 1+10+RD_LATENCY+8+CS_GAP clk; rd_valid in the first hold cycle.
// Backpressure: cmd_ready high only in IDLE; host must hold cmd_valid/cmd_data until accepted.
// Optional: define SPI_RAM_MASTER_SEQ_CHECK_EN to add the sticky seq_err opcode-ordering flag.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int CS_GAP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
  output logic              seq_err,
`endif
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  // Counter reload values: each state counts down to zero, so load length-1.
  localparam logic [3:0] LD_SHIFT  = 4'(CMD_W - 1);
  localparam logic [3:0] LD_RDWAIT = 4'(RD_LATENCY - 1);
  localparam logic [3:0] LD_RDSH   = 4'(DATA_W - 1);
  localparam logic [3:0] LD_GAP    = 4'(CS_GAP - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic [CMD_W-1:0]    r_shift;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_rd_shift;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_ss_n;
  logic                r_mosi;
  logic                w_ss_n_nxt;
  logic                w_mosi_nxt;
  logic                w_rd_done;
  logic                w_cmd_ready;
  logic                w_accept;
  logic [DATA_W-1:0]   w_rd_byte;

  // Ready is masked by rst so a command presented during reset is never taken.
  assign w_cmd_ready = (r_state == IDLE) && !rst;
  assign w_accept    = cmd_valid && w_cmd_ready;
  assign w_rd_byte   = {r_rd_shift[DATA_W-2:0], MISO};

  // Next-state, counter reload and next registered pin values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_done   = 1'b0;
    w_ss_n_nxt  = 1'b1;
    w_mosi_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = CS_SETUP;
          w_cnt_nxt   = 4'd0;
        end
      end
      CS_SETUP: begin
        w_state_nxt = SHIFT;
        w_cnt_nxt   = LD_SHIFT;
      end
      SHIFT: begin
        if (r_cnt == 4'd0) begin
          if (op_is_read_data(r_op)) begin
            w_state_nxt = RD_WAIT;
            w_cnt_nxt   = LD_RDWAIT;
          end else begin
            w_state_nxt = CS_HOLD;
            w_cnt_nxt   = LD_GAP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RD_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RD_SHIFT;
          w_cnt_nxt   = LD_RDSH;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RD_SHIFT: begin
        if (r_cnt == 4'd0) begin
          w_rd_done   = 1'b1;
          w_state_nxt = CS_HOLD;
          w_cnt_nxt   = LD_GAP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      CS_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    // Pins are registered from the next state so they line up with the state they belong to.
    w_ss_n_nxt = (w_state_nxt == IDLE) || (w_state_nxt == CS_HOLD);
    if (w_state_nxt == SHIFT) begin
      // First shift bit comes straight from the latched word; later ones from the
      // register after it has been shifted once per SHIFT cycle.
      w_mosi_nxt = (r_state == CS_SETUP) ? r_shift[CMD_W-1] : r_shift[CMD_W-2];
    end
  end

  // State register and bit/cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered SPI pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_n <= 1'b1;
      r_mosi <= 1'b0;
    end else begin
      r_ss_n <= w_ss_n_nxt;
      r_mosi <= w_mosi_nxt;
    end
  end

  // Command latch and MOSI shift register; later cmd_data changes cannot reach the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_op    <= OP_WR_ADDR;
    end else if (w_accept) begin
      r_shift <= cmd_data;
      r_op    <= cmd_data[CMD_W-1:CMD_W-2];
    end else if (r_state == SHIFT) begin
      r_shift <= {r_shift[CMD_W-2:0], 1'b0};
    end
  end

  // MISO capture, read byte hold and one-cycle rd_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_shift <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_done;
      if (r_state == RD_SHIFT) begin
        r_rd_shift <= w_rd_byte;
      end
      if (w_rd_done) begin
        r_rd_data <= w_rd_byte;
      end
    end
  end

`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
  logic [1:0] r_last_op;
  logic       r_last_vld;
  logic       r_seq_err;
  logic       w_seq_bad;
  logic [1:0] w_new_op;

  assign w_new_op  = cmd_data[CMD_W-1:CMD_W-2];
  assign w_seq_bad = ((w_new_op == OP_WR_DATA) && !(r_last_vld && (r_last_op == OP_WR_ADDR))) ||
                     ((w_new_op == OP_RD_DATA) && !(r_last_vld && (r_last_op == OP_RD_ADDR)));

  // Track the last issued opcode; a data opcode without its matching address opcode sets a sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_op  <= OP_WR_ADDR;
      r_last_vld <= 1'b0;
      r_seq_err  <= 1'b0;
    end else if (w_accept) begin
      r_last_op  <= w_new_op;
      r_last_vld <= 1'b1;
      if (w_seq_bad) begin
        r_seq_err <= 1'b1;
      end
    end
  end

  assign seq_err = r_seq_err;
`endif

  assign cmd_ready = w_cmd_ready;
  assign busy      = (r_state != IDLE);
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

endmodule
